// File: rtl/audio_feed_pkg.sv
`default_nettype none
// ============================================================================
// Module : audio_feed_pkg
// Brief  : Shared register map, control bits and LED pattern helpers.
// Rev    : 1.0
// ============================================================================
package audio_feed_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_MAG    = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   localparam int CTRL_MODE = 0;
   localparam int CTRL_DOT  = 1;
   localparam int CTRL_CLR  = 2;

   localparam int LED_N_DEF = 10;
   localparam int LVL_W     = $clog2(LED_N_DEF + 1);
   localparam int PAT_W     = 32;

   typedef enum logic {
      MODE_PIO = 1'b0,
      MODE_VU  = 1'b1
   } led_mode_e;

   // Bits [n-1:0] set; callers truncate to their LED count.
   function automatic logic [PAT_W-1:0] therm(input logic [LVL_W-1:0] n);
      return (PAT_W'(1) << n) - PAT_W'(1);
   endfunction

   function automatic logic [PAT_W-1:0] onehot(input logic [LVL_W-1:0] n);
      return PAT_W'(1) << n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/audio_feed_level_quant.sv
`default_nettype none
// ============================================================================
// Module : audio_feed_level_quant
// Brief  : S1 magnitude register and combinational magnitude-to-level map.
// Rev    : 1.0
// ============================================================================
module audio_feed_level_quant
   import audio_feed_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int LED_N    = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_clear,
   input  logic [SAMPLE_W-1:0]   i_data,
   input  logic                  i_valid,
   output logic [SAMPLE_W-2:0]   o_mag,
   output logic                  o_v1,
   output logic [LVL_W-1:0]      o_lvl,
   output logic                  o_full_scale
);

   localparam int SHIFT = SAMPLE_W - 1 - LED_N;

   logic [SAMPLE_W-2:0] r_mag;
   logic                r_v1;
   logic [SAMPLE_W-2:0] w_neg;
   logic [SAMPLE_W-2:0] w_abs;
   int                  w_msb;
   int                  w_raw;
   logic                w_nz;
   logic [LVL_W-1:0]    w_lvl;

   assign w_neg = ~i_data[SAMPLE_W-2:0] + 1'b1;

   // The most negative code has no positive twin; pin it to full scale.
   always_comb begin
      w_abs = i_data[SAMPLE_W-2:0];
      if (i_data[SAMPLE_W-1]) begin
         if (i_data[SAMPLE_W-2:0] == '0)
            w_abs = '1;
         else
            w_abs = w_neg;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mag <= '0;
         r_v1  <= 1'b0;
      end else begin
         r_v1 <= i_valid & ~i_clear;
         if (i_valid)
            r_mag <= w_abs;
      end
   end

   always_comb begin
      w_msb = 0;
      w_nz  = 1'b0;
      for (int i = 0; i < SAMPLE_W - 1; i++) begin
         if (r_mag[i]) begin
            w_msb = i;
            w_nz  = 1'b1;
         end
      end
      w_raw = w_msb + 1 - SHIFT;
      if (!w_nz || w_raw <= 0)
         w_lvl = '0;
      else if (w_raw >= LED_N)
         w_lvl = LVL_W'(LED_N);
      else
         w_lvl = LVL_W'(w_raw);
   end

   assign o_mag        = r_mag;
   assign o_v1         = r_v1;
   assign o_lvl        = w_lvl;
   assign o_full_scale = (r_mag == '1);

endmodule
`default_nettype wire

// File: rtl/audio_feed_led_vu_meter.sv
`default_nettype none
// ============================================================================
// Module : audio_feed_led_vu_meter
// Brief  : Peak-with-decay LED bar meter on an audio stream, with PIO bypass.
// Rev    : 1.0
// ============================================================================
module audio_feed_led_vu_meter
   import audio_feed_pkg::*;
#(
   parameter int SAMPLE_W          = 16,
   parameter int LED_N             = 10,
   parameter int DECAY_SAMPLES     = 2400,
   parameter int PEAK_HOLD_SAMPLES = 24000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   input  logic [LED_N-1:0]    pio_pattern,
   input  logic [SAMPLE_W-1:0] snk_data,
   input  logic                snk_valid,
   output logic                snk_ready,
   output logic [LED_N-1:0]    led
);

   localparam int DCNT_W = $clog2(DECAY_SAMPLES);
   localparam int HCNT_W = $clog2(PEAK_HOLD_SAMPLES);

   led_mode_e           r_mode;
   logic                r_dot;
   logic                r_clip;
   logic [LVL_W-1:0]    r_bar;
   logic [LVL_W-1:0]    r_peak;
   logic [DCNT_W-1:0]   r_dcnt;
   logic [HCNT_W-1:0]   r_hcnt;
   logic [LED_N-1:0]    r_vu_pat;
   logic [LED_N-1:0]    r_led;

   logic                w_wr;
   logic                w_ctrl_wr;
   logic                w_stat_wr;
   logic                w_clear;
   logic [SAMPLE_W-2:0] w_mag;
   logic                w_v1;
   logic [LVL_W-1:0]    w_lvl;
   logic                w_full_scale;
   logic [LVL_W-1:0]    w_bar_nxt;
   logic [LVL_W-1:0]    w_peak_nxt;
   logic [DCNT_W-1:0]   w_dcnt_nxt;
   logic [HCNT_W-1:0]   w_hcnt_nxt;
   logic [LED_N-1:0]    w_vu;
   logic                w_unused;

   assign w_wr      = chipselect & ~write_n;
   assign w_ctrl_wr = w_wr && (address == REG_CTRL);
   assign w_stat_wr = w_wr && (address == REG_STATUS);
   assign w_clear   = w_ctrl_wr && writedata[CTRL_CLR];
   assign w_unused  = ^writedata[31:3];
   assign snk_ready = 1'b1;

   audio_feed_level_quant #(
      .SAMPLE_W (SAMPLE_W),
      .LED_N    (LED_N)
   ) u_quant (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_clear      (w_clear),
      .i_data       (snk_data),
      .i_valid      (snk_valid),
      .o_mag        (w_mag),
      .o_v1         (w_v1),
      .o_lvl        (w_lvl),
      .o_full_scale (w_full_scale)
   );

   // The decrement branch is only reached with r_bar > w_lvl >= 0, so no underflow.
   always_comb begin
      w_bar_nxt  = r_bar;
      w_dcnt_nxt = r_dcnt;
      if (w_lvl >= r_bar) begin
         w_bar_nxt  = w_lvl;
         w_dcnt_nxt = '0;
      end else if (r_dcnt == DCNT_W'(DECAY_SAMPLES - 1)) begin
         w_bar_nxt  = r_bar - 1'b1;
         w_dcnt_nxt = '0;
      end else begin
         w_dcnt_nxt = r_dcnt + 1'b1;
      end

      w_peak_nxt = r_peak;
      w_hcnt_nxt = r_hcnt;
      if (w_lvl >= r_peak) begin
         w_peak_nxt = w_lvl;
         w_hcnt_nxt = '0;
      end else if (r_hcnt == HCNT_W'(PEAK_HOLD_SAMPLES - 1)) begin
         w_peak_nxt = w_bar_nxt;
         w_hcnt_nxt = '0;
      end else begin
         w_hcnt_nxt = r_hcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode <= MODE_PIO;
         r_dot  <= 1'b0;
         r_clip <= 1'b0;
         r_bar  <= '0;
         r_peak <= '0;
         r_dcnt <= '0;
         r_hcnt <= '0;
      end else begin
         if (w_ctrl_wr) begin
            r_mode <= led_mode_e'(writedata[CTRL_MODE]);
            r_dot  <= writedata[CTRL_DOT];
         end

         if (w_clear) begin
            r_bar  <= '0;
            r_peak <= '0;
            r_dcnt <= '0;
            r_hcnt <= '0;
         end else if (w_v1) begin
            r_bar  <= w_bar_nxt;
            r_peak <= w_peak_nxt;
            r_dcnt <= w_dcnt_nxt;
            r_hcnt <= w_hcnt_nxt;
         end

         // Clip detection is independent of clear and beats a status write.
         if (w_v1 && w_full_scale)
            r_clip <= 1'b1;
         else if (w_stat_wr)
            r_clip <= 1'b0;
      end
   end

   assign w_vu = LED_N'(therm(r_bar)) |
                 ((r_dot && (r_peak != '0)) ? LED_N'(onehot(r_peak - 1'b1)) : '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vu_pat <= '0;
         r_led    <= '0;
      end else begin
         r_vu_pat <= w_vu;
         r_led    <= (r_mode == MODE_VU) ? r_vu_pat : pio_pattern;
      end
   end

   assign led = r_led;

   always_comb begin
      readdata = '0;
      case (address)
         REG_CTRL: begin
            readdata[CTRL_MODE] = r_mode;
            readdata[CTRL_DOT]  = r_dot;
         end
         REG_STATUS: begin
            readdata[LVL_W-1:0]       = r_bar;
            readdata[2*LVL_W-1:LVL_W] = r_peak;
            readdata[2*LVL_W]         = r_clip;
         end
         REG_MAG:  readdata[SAMPLE_W-2:0] = w_mag;
         REG_RSVD: readdata = '0;
         default:  readdata = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_audio_feed_led_vu_meter.sv
`default_nettype none
// Directed bench for audio_feed_led_vu_meter: pass-through, bar/peak dynamics,
// register access, same-cycle collisions and asynchronous reset.
module tb_audio_feed_led_vu_meter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [9:0]  pio_pattern = 10'd0;
   logic [15:0] snk_data = 16'd0;
   logic        snk_valid = 1'b0;
   logic        snk_ready;
   logic [9:0]  led;

   int n_cmp = 0;
   int n_err = 0;

   audio_feed_led_vu_meter #(
      .SAMPLE_W          (16),
      .LED_N             (10),
      .DECAY_SAMPLES     (2400),
      .PEAK_HOLD_SAMPLES (24000)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .pio_pattern (pio_pattern),
      .snk_data    (snk_data),
      .snk_valid   (snk_valid),
      .snk_ready   (snk_ready),
      .led         (led)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      #1;
      chk(tag, readdata, exp);
   endtask

   task automatic send(input logic [15:0] d);
      snk_valid = 1'b1;
      snk_data  = d;
      tick();
      snk_valid = 1'b0;
   endtask

   initial begin
      // Reset and PIO pass-through
      repeat (2) @(negedge clk);
      chk("led_in_reset", 32'(led), 32'h000);
      chk("ready_in_reset", 32'(snk_ready), 32'h1);
      reset_n = 1'b1;
      rd("status_after_reset", 2'd1, 32'h0);
      rd("ctrl_after_reset", 2'd0, 32'h0);
      pio_pattern = 10'h2A5;
      chk("led_before_pio", 32'(led), 32'h000);
      tick();
      chk("led_pio_pass", 32'(led), 32'h2A5);
      chk("ready_run", 32'(snk_ready), 32'h1);

      // Single sample of magnitude 1024: level 6, three-edge latency
      wr(2'd0, 32'h1);
      send(16'h0400);
      tick();
      rd("status_lvl6", 2'd1, 32'h066);
      chk("led_lat_e1", 32'(led), 32'h000);
      tick();
      chk("led_lat_e2", 32'(led), 32'h000);
      tick();
      chk("led_lvl6", 32'(led), 32'h03F);
      rd("mag_1024", 2'd2, 32'h400);
      wr(2'd0, 32'h3);
      repeat (3) tick();
      chk("led_dot_overlap", 32'(led), 32'h03F);
      rd("ctrl_mode_dot", 2'd0, 32'h3);

      // Full-scale negative peak, decay and peak hold
      wr(2'd0, 32'h7);
      rd("ctrl_clr_reads0", 2'd0, 32'h3);
      snk_valid = 1'b1;
      snk_data  = 16'h8000;
      tick();
      rd("mag_sat", 2'd2, 32'h7FFF);
      snk_data = 16'h0000;
      repeat (2399) tick();
      snk_valid = 1'b0;
      tick();
      rd("status_2399_zeros", 2'd1, 32'h1AA);
      send(16'h0000);
      tick();
      rd("status_2400_zeros", 2'd1, 32'h1A9);
      tick();
      tick();
      chk("led_bar9_dot10", 32'(led), 32'h3FF);
      wr(2'd0, 32'h1);
      tick();
      tick();
      chk("led_bar9_nodot", 32'(led), 32'h1FF);
      snk_valid = 1'b1;
      repeat (21599) tick();
      snk_valid = 1'b0;
      tick();
      rd("status_23999_zeros", 2'd1, 32'h1A1);
      send(16'h0000);
      tick();
      rd("status_24000_zeros", 2'd1, 32'h100);
      wr(2'd1, 32'h0);
      rd("status_clip_cleared", 2'd1, 32'h000);

      // Decay counts valid samples only, not cycles
      wr(2'd0, 32'h7);
      send(16'h7FFF);
      for (int i = 0; i < 2399; i++) begin
         send(16'h0000);
         tick();
      end
      repeat (40) tick();
      rd("gap_status_before", 2'd1, 32'h1AA);
      rd("gap_mag_zero", 2'd2, 32'h0);
      send(16'h0000);
      tick();
      rd("gap_status_after", 2'd1, 32'h1A9);

      // Status write colliding with a clipping sample in S2
      wr(2'd1, 32'h0);
      rd("clip_cleared_again", 2'd1, 32'h0A9);
      snk_valid = 1'b1;
      snk_data  = 16'h7FFF;
      tick();
      snk_valid  = 1'b0;
      address    = 2'd1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      rd("status_wr_vs_clip", 2'd1, 32'h1AA);

      // CTRL clear colliding with a full-scale sample in S2
      wr(2'd1, 32'h0);
      rd("pre_clear_status", 2'd1, 32'h0AA);
      snk_valid = 1'b1;
      snk_data  = 16'h7FFF;
      tick();
      snk_valid  = 1'b0;
      address    = 2'd0;
      writedata  = 32'h5;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      rd("clear_vs_sample", 2'd1, 32'h100);
      rd("ctrl_after_clear", 2'd0, 32'h1);
      tick();
      rd("clear_holds", 2'd1, 32'h100);

      // Asynchronous reset in the middle of a decay at bar 7
      wr(2'd1, 32'h0);
      send(16'h0800);
      snk_valid = 1'b1;
      snk_data  = 16'h0000;
      repeat (100) tick();
      snk_valid = 1'b0;
      tick();
      rd("status_bar7", 2'd1, 32'h077);
      tick();
      tick();
      chk("led_bar7", 32'(led), 32'h07F);
      reset_n = 1'b0;
      #1;
      chk("led_async_reset", 32'(led), 32'h000);
      rd("status_async_reset", 2'd1, 32'h0);
      rd("ctrl_async_reset", 2'd0, 32'h0);
      rd("mag_async_reset", 2'd2, 32'h0);
      chk("ready_async_reset", 32'(snk_ready), 32'h1);
      @(negedge clk);
      reset_n = 1'b1;
      wr(2'd0, 32'h1);
      send(16'h0020);
      tick();
      rd("status_after_rst_sample", 2'd1, 32'h011);
      tick();
      tick();
      chk("led_after_rst_sample", 32'(led), 32'h001);
      rd("rsvd_reads0", 2'd3, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
